// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator with branch/jump target adder, registered behind a
// valid/ready stage with an optional skid entry and synchronous flush.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] tgt_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Upper bits are pre-filled with instr[31]; each format then overwrites its low field.
    function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        entry_t e;
        e.imm     = {XLEN{instr[31]}};
        e.fmt     = FMT_R;
        e.illegal = 1'b0;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                e.fmt       = FMT_I;
                e.imm[11:0] = instr[31:20];
            end
            7'b0100011: begin
                e.fmt       = FMT_S;
                e.imm[11:0] = {instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                e.fmt       = FMT_B;
                e.imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                e.fmt       = FMT_U;
                e.imm[31:0] = {instr[31:12], 12'b0};
            end
            7'b1101111: begin
                e.fmt       = FMT_J;
                e.imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            7'b0110011: begin
                e.fmt = FMT_R;
                e.imm = '0;
            end
            default: begin
                e.fmt     = FMT_ILL;
                e.illegal = 1'b1;
                e.imm     = '0;
            end
        endcase
        e.tgt = pc + e.imm;
        return e;
    endfunction

    state_t state_r;
    state_t state_next_s;
    entry_t main_r;
    entry_t skid_r;
    entry_t new_s;
    logic   main_valid_r;
    logic   in_ready_r;
    logic   in_ready_s;
    logic   accept_s;
    logic   load_main_new_s;
    logic   load_main_skid_s;
    logic   load_skid_s;

    assign new_s      = decode(instr_i, pc_i);
    assign in_ready_s = (SKID != 0) ? in_ready_r : (!main_valid_r || out_ready_i);
    assign accept_s   = in_valid_i && in_ready_s;

    // Next-state and load selection; flush overrides every transfer.
    always_comb begin
        state_next_s     = state_r;
        load_main_new_s  = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush_i) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        load_main_new_s = 1'b1;
                        state_next_s    = ST_ONE;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && out_ready_i) begin
                        load_main_new_s = 1'b1;
                        state_next_s    = ST_ONE;
                    end else if (accept_s) begin
                        // Only reachable with a skid entry; main is stalled so park the newcomer.
                        if (SKID != 0) begin
                            load_skid_s  = 1'b1;
                            state_next_s = ST_TWO;
                        end else begin
                            state_next_s = ST_ONE;
                        end
                    end else if (out_ready_i) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_ready_i) begin
                        load_main_skid_s = 1'b1;
                        state_next_s     = ST_ONE;
                    end else begin
                        state_next_s = ST_TWO;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register plus registered valid/ready flags derived from the next state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= ST_EMPTY;
            main_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            main_valid_r <= (state_next_s != ST_EMPTY);
            in_ready_r   <= (state_next_s != ST_TWO);
        end
    end

    // Payload registers for the output entry and the skid entry.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_r <= '0;
            skid_r <= '0;
        end else if (flush_i) begin
            main_r <= '0;
            skid_r <= '0;
        end else begin
            if (load_main_new_s) begin
                main_r <= new_s;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= new_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = main_valid_r;
    assign imm_o       = main_r.imm;
    assign tgt_o       = main_r.tgt;
    assign fmt_o       = main_r.fmt;
    assign illegal_o   = main_r.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit skid instance and a 64-bit no-skid instance share stimulus;
// each is scored against an arithmetic decode model and an occupancy-count handshake model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [63:0] pc = 64'h0;

    logic        rdy32, ov32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic        rdy64, ov64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SKID(1)) u_dut32 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy32), .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(ov32),
        .out_ready_i(out_ready), .imm_o(imm32), .tgt_o(tgt32), .fmt_o(fmt32),
        .illegal_o(ill32));

    imm_gen_pipe #(.XLEN(64), .SKID(0)) u_dut64 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy64), .instr_i(instr), .pc_i(pc), .out_valid_o(ov64),
        .out_ready_i(out_ready), .imm_o(imm64), .tgt_o(tgt64), .fmt_o(fmt64),
        .illegal_o(ill64));

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic [63:0] obs_imm [2];
    logic [63:0] obs_tgt [2];
    logic [2:0]  obs_fmt [2];
    logic        obs_ill [2];
    logic        obs_vld [2];
    logic        obs_rdy [2];

    assign obs_imm[0] = {32'h0, imm32};
    assign obs_imm[1] = imm64;
    assign obs_tgt[0] = {32'h0, tgt32};
    assign obs_tgt[1] = tgt64;
    assign obs_fmt[0] = fmt32;
    assign obs_fmt[1] = fmt64;
    assign obs_ill[0] = ill32;
    assign obs_ill[1] = ill64;
    assign obs_vld[0] = ov32;
    assign obs_vld[1] = ov64;
    assign obs_rdy[0] = rdy32;
    assign obs_rdy[1] = rdy64;

    exp_t sb [2][256];
    int   head [2];
    int   tail [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Immediate value built arithmetically from instruction fields, then two's-complement wrapped.
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] p);
        exp_t   e;
        longint v;
        int     w;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        v = 0;
        w = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin
                e.fmt = 3'd1; v = longint'(ins[31:20]); w = 12;
            end
            7'h23: begin
                e.fmt = 3'd2; v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); w = 12;
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                    longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                w = 13;
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4; v = longint'(ins[31:12]) * 4096; w = 32;
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                    longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                w = 21;
            end
            7'h33: begin
                e.fmt = 3'd0;
            end
            default: begin
                e.fmt = 3'd7; e.ill = 1'b1;
            end
        endcase
        if (w > 0 && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        e.imm = 64'(v);
        e.tgt = p + 64'(v);
        return e;
    endfunction

    function automatic logic [63:0] msk(input int k, input logic [63:0] v);
        return (k == 0) ? {32'h0, v[31:0]} : v;
    endfunction

    // Scoreboard: entry count predicts valid/ready, queue head predicts the presented payload.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                head[k] = 0;
                tail[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int   cnt;
                logic erdy;
                exp_t f;
                cnt  = tail[k] - head[k];
                erdy = (k == 0) ? (cnt < 2) : (cnt == 0 || out_ready);
                check_val($sformatf("rdy%0d", k), {63'h0, obs_rdy[k]}, {63'h0, erdy});
                check_val($sformatf("vld%0d", k), {63'h0, obs_vld[k]}, {63'h0, cnt > 0});
                if (cnt > 0) begin
                    f = sb[k][head[k] % 256];
                    check_val($sformatf("imm%0d", k), obs_imm[k], msk(k, f.imm));
                    check_val($sformatf("tgt%0d", k), obs_tgt[k], msk(k, f.tgt));
                    check_val($sformatf("fmt%0d", k), {61'h0, obs_fmt[k]}, {61'h0, f.fmt});
                    check_val($sformatf("ill%0d", k), {63'h0, obs_ill[k]}, {63'h0, f.ill});
                end
                if (flush) begin
                    head[k] = tail[k];
                end else begin
                    if (cnt > 0 && out_ready) head[k]++;
                    if (in_valid && erdy) begin
                        sb[k][tail[k] % 256] = ref_dec(instr, pc);
                        tail[k]++;
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        instr     = ins;
        pc        = p;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_ov32"}, {63'h0, ov32}, 64'h0);
        check_val({tag, "_imm32"}, {32'h0, imm32}, 64'h0);
        check_val({tag, "_tgt32"}, {32'h0, tgt32}, 64'h0);
        check_val({tag, "_fmt32"}, {61'h0, fmt32}, 64'h0);
        check_val({tag, "_ill32"}, {63'h0, ill32}, 64'h0);
        check_val({tag, "_ov64"}, {63'h0, ov64}, 64'h0);
        check_val({tag, "_imm64"}, imm64, 64'h0);
        check_val({tag, "_tgt64"}, tgt64, 64'h0);
        check_val({tag, "_fmt64"}, {61'h0, fmt64}, 64'h0);
        check_val({tag, "_ill64"}, {63'h0, ill64}, 64'h0);
    endtask

    task automatic directed(input string tag, input logic [31:0] ins, input logic [63:0] p,
                            input logic [63:0] eimm, input logic [63:0] etgt, input logic [2:0] efmt);
        drive(1'b1, ins, p, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        check_val({tag, "_ov32"}, {63'h0, ov32}, 64'h1);
        check_val({tag, "_imm32"}, {32'h0, imm32}, {32'h0, eimm[31:0]});
        check_val({tag, "_tgt32"}, {32'h0, tgt32}, {32'h0, etgt[31:0]});
        check_val({tag, "_fmt32"}, {61'h0, fmt32}, {61'h0, efmt});
        check_val({tag, "_ill32"}, {63'h0, ill32}, {63'h0, efmt == 3'd7});
        check_val({tag, "_ov64"}, {63'h0, ov64}, 64'h1);
        check_val({tag, "_imm64"}, imm64, eimm);
        check_val({tag, "_tgt64"}, tgt64, etgt);
        check_val({tag, "_fmt64"}, {61'h0, fmt64}, {61'h0, efmt});
    endtask

    logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("in_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rel_rdy32", {63'h0, rdy32}, 64'h1);
        check_val("rel_rdy64", {63'h0, rdy64}, 64'h1);
        check_zero("after_rel");

        directed("beq", 32'hFE000EE3, 64'h100, 64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC, 3'd3);
        directed("sw", 32'h00512423, 64'h0, 64'h8, 64'h8, 3'd2);
        directed("lui", 32'h123450B7, 64'h0, 64'h12345000, 64'h12345000, 3'd4);
        directed("jal", 32'h001000EF, 64'h1000, 64'h800, 64'h1800, 3'd5);
        directed("ill", 32'h0000007F, 64'h40, 64'h0, 64'h40, 3'd7);
        directed("lui_neg", 32'h80000037, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 3'd4);
        directed("b_wrap", 32'h02000063, 64'hFFFFFFFFFFFFFFF0, 64'h20, 64'h10, 3'd3);
        directed("rtype", 32'h00208033, 64'h200, 64'h0, 64'h200, 3'd0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Stall with A, B, C offered back to back; skid instance must refuse C.
        drive(1'b1, 32'h00100093, 64'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h00200093, 64'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h00300093, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("stall_rdy32", {63'h0, rdy32}, 64'h0);
        check_val("stall_imm32", {32'h0, imm32}, 64'h1);
        drive(1'b1, 32'h00300093, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("rel_a_vld", {63'h0, ov32}, 64'h1);
        check_val("rel_a_imm", {32'h0, imm32}, 64'h1);
        drive(1'b1, 32'h00300093, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("rel_b_vld", {63'h0, ov32}, 64'h1);
        check_val("rel_b_imm", {32'h0, imm32}, 64'h2);
        check_val("rel_b_rdy", {63'h0, rdy32}, 64'h1);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("rel_c_vld", {63'h0, ov32}, 64'h1);
        check_val("rel_c_imm", {32'h0, imm32}, 64'h3);
        repeat (3) drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Flush while the skid instance holds two entries, with an input offered.
        drive(1'b1, 32'h00100093, 64'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h00200093, 64'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("two_rdy32", {63'h0, rdy32}, 64'h0);
        drive(1'b1, 32'h00300093, 64'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("fl_ov32", {63'h0, ov32}, 64'h0);
        check_val("fl_rdy32", {63'h0, rdy32}, 64'h1);
        check_val("fl_ov64", {63'h0, ov64}, 64'h0);
        check_val("fl_rdy64", {63'h0, rdy64}, 64'h1);

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, 32'hFE000EE3, 64'h100, 1'b0, 1'b0);
        drive(1'b1, 32'h001000EF, 64'h1000, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        check_zero("mid_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst2_rdy32", {63'h0, rdy32}, 64'h1);
        check_val("rst2_rdy64", {63'h0, rdy64}, 64'h1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            int          idx;
            r   = $urandom;
            idx = $urandom_range(0, 11);
            if (idx < 11) r[6:0] = ops[idx];
            drive($urandom_range(0, 3) != 0, r, {$urandom, $urandom},
                  $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        repeat (4) drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
